// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - pipelined MIPS main/ALU decoder carrying controls through E, M and W
// Extended ops (andi, ori, slti, bne) decode only when PIPE_CTRL_EXT_OPS_EN is defined.
module pipe_controller #(
  parameter int ALUC_W       = 3,
  parameter bit STRICT_FUNCT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [5:0]        opcode_d_i,
  input  logic [5:0]        funct_d_i,
  input  logic              freeze_i,
  input  logic              flush_e_i,
  output logic              branch_d_o,
  output logic              branch_ne_d_o,
  output logic              jump_d_o,
  output logic              illegal_d_o,
  output logic              rfwrite_e_o,
  output logic              memtorf_e_o,
  output logic              alusrc_e_o,
  output logic              rfdst_e_o,
  output logic              imm_zext_e_o,
  output logic [ALUC_W-1:0] alucontrol_e_o,
  output logic              rfwrite_m_o,
  output logic              memtorf_m_o,
  output logic              memwrite_m_o,
  output logic              rfwrite_w_o,
  output logic              memtorf_w_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef PIPE_CTRL_EXT_OPS_EN
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  logic       w_rfwrite;
  logic       w_memtorf;
  logic       w_memwrite;
  logic       w_alusrc;
  logic       w_rfdst;
  logic [2:0] w_alucontrol;
  logic       w_branch;
  logic       w_jump;
  logic       w_illegal;
`ifdef PIPE_CTRL_EXT_OPS_EN
  logic       w_branch_ne;
  logic       w_imm_zext;
`endif

  logic       r_rfwrite_e;
  logic       r_memtorf_e;
  logic       r_memwrite_e;
  logic       r_alusrc_e;
  logic       r_rfdst_e;
  logic [2:0] r_alucontrol_e;
  logic       r_rfwrite_m;
  logic       r_memtorf_m;
  logic       r_memwrite_m;
  logic       r_rfwrite_w;
  logic       r_memtorf_w;
`ifdef PIPE_CTRL_EXT_OPS_EN
  logic       r_imm_zext_e;
`endif

  // Illegal encodings collapse to a bubble so nothing downstream writes state.
  always_comb begin
    w_rfwrite    = 1'b0;
    w_memtorf    = 1'b0;
    w_memwrite   = 1'b0;
    w_alusrc     = 1'b0;
    w_rfdst      = 1'b0;
    w_alucontrol = ALU_AND;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_illegal    = 1'b0;
`ifdef PIPE_CTRL_EXT_OPS_EN
    w_branch_ne  = 1'b0;
    w_imm_zext   = 1'b0;
`endif
    case (opcode_d_i)
      OP_RTYPE: begin
        if (funct_d_i != FN_NOP) begin
          w_rfwrite = 1'b1;
          w_rfdst   = 1'b1;
          case (funct_d_i)
            FN_ADD:  w_alucontrol = ALU_ADD;
            FN_SUB:  w_alucontrol = ALU_SUB;
            FN_AND:  w_alucontrol = ALU_AND;
            FN_OR:   w_alucontrol = ALU_OR;
            FN_SLT:  w_alucontrol = ALU_SLT;
            default: begin
              w_alucontrol = ALU_ADD;
              w_illegal    = STRICT_FUNCT;
            end
          endcase
        end
      end
      OP_LW: begin
        w_rfwrite    = 1'b1;
        w_alusrc     = 1'b1;
        w_memtorf    = 1'b1;
        w_alucontrol = ALU_ADD;
      end
      OP_SW: begin
        w_alusrc     = 1'b1;
        w_memwrite   = 1'b1;
        w_alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        w_branch     = 1'b1;
        w_alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        w_rfwrite    = 1'b1;
        w_alusrc     = 1'b1;
        w_alucontrol = ALU_ADD;
      end
      OP_J: begin
        w_jump = 1'b1;
      end
`ifdef PIPE_CTRL_EXT_OPS_EN
      OP_ANDI: begin
        w_rfwrite    = 1'b1;
        w_alusrc     = 1'b1;
        w_imm_zext   = 1'b1;
        w_alucontrol = ALU_AND;
      end
      OP_ORI: begin
        w_rfwrite    = 1'b1;
        w_alusrc     = 1'b1;
        w_imm_zext   = 1'b1;
        w_alucontrol = ALU_OR;
      end
      OP_SLTI: begin
        w_rfwrite    = 1'b1;
        w_alusrc     = 1'b1;
        w_alucontrol = ALU_SLT;
      end
      OP_BNE: begin
        w_branch     = 1'b1;
        w_branch_ne  = 1'b1;
        w_alucontrol = ALU_SUB;
      end
`endif
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal) begin
      w_rfwrite    = 1'b0;
      w_memtorf    = 1'b0;
      w_memwrite   = 1'b0;
      w_alusrc     = 1'b0;
      w_rfdst      = 1'b0;
      w_alucontrol = ALU_AND;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
`ifdef PIPE_CTRL_EXT_OPS_EN
      w_branch_ne  = 1'b0;
      w_imm_zext   = 1'b0;
`endif
    end
  end

  // Freeze outranks flush: a stalled E register must keep its instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rfwrite_e    <= 1'b0;
      r_memtorf_e    <= 1'b0;
      r_memwrite_e   <= 1'b0;
      r_alusrc_e     <= 1'b0;
      r_rfdst_e      <= 1'b0;
      r_alucontrol_e <= ALU_AND;
      r_rfwrite_m    <= 1'b0;
      r_memtorf_m    <= 1'b0;
      r_memwrite_m   <= 1'b0;
      r_rfwrite_w    <= 1'b0;
      r_memtorf_w    <= 1'b0;
    end else if (!freeze_i) begin
      if (flush_e_i) begin
        r_rfwrite_e    <= 1'b0;
        r_memtorf_e    <= 1'b0;
        r_memwrite_e   <= 1'b0;
        r_alusrc_e     <= 1'b0;
        r_rfdst_e      <= 1'b0;
        r_alucontrol_e <= ALU_AND;
      end else begin
        r_rfwrite_e    <= w_rfwrite;
        r_memtorf_e    <= w_memtorf;
        r_memwrite_e   <= w_memwrite;
        r_alusrc_e     <= w_alusrc;
        r_rfdst_e      <= w_rfdst;
        r_alucontrol_e <= w_alucontrol;
      end
      r_rfwrite_m  <= r_rfwrite_e;
      r_memtorf_m  <= r_memtorf_e;
      r_memwrite_m <= r_memwrite_e;
      r_rfwrite_w  <= r_rfwrite_m;
      r_memtorf_w  <= r_memtorf_m;
    end
  end

`ifdef PIPE_CTRL_EXT_OPS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_imm_zext_e <= 1'b0;
    end else if (!freeze_i) begin
      r_imm_zext_e <= flush_e_i ? 1'b0 : w_imm_zext;
    end
  end

  assign branch_ne_d_o = w_branch_ne;
  assign imm_zext_e_o  = r_imm_zext_e;
`else
  assign branch_ne_d_o = 1'b0;
  assign imm_zext_e_o  = 1'b0;
`endif

  assign branch_d_o     = w_branch;
  assign jump_d_o       = w_jump;
  assign illegal_d_o    = w_illegal;

  assign rfwrite_e_o    = r_rfwrite_e;
  assign memtorf_e_o    = r_memtorf_e;
  assign alusrc_e_o     = r_alusrc_e;
  assign rfdst_e_o      = r_rfdst_e;
  assign alucontrol_e_o = ALUC_W'(r_alucontrol_e);

  assign rfwrite_m_o    = r_rfwrite_m;
  assign memtorf_m_o    = r_memtorf_m;
  assign memwrite_m_o   = r_memwrite_m;

  assign rfwrite_w_o    = r_rfwrite_w;
  assign memtorf_w_o    = r_memtorf_w;

endmodule
